demux4_reg: RTL and testbench
=============================

Name: demux4_reg

Overview:
Registered 1-to-4 demultiplexer: the distribution end of the 4:1 mux path. It takes one WIDTH-bit input word under a valid/ready handshake and steers it to one of four output lanes. Each lane has a one-entry holding register with its own valid/ready handshake. The lane is chosen by an explicit select input, or by an internal round-robin pointer when auto mode is on.

Parameters:
WIDTH, 4, data width of the input word and of each output lane

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
d  input  WIDTH  input data word
s  input  2  explicit lane select, used when auto=0
auto  input  1  1 = round-robin lane selection; 0 = lane given by s
in_valid  input  1  d is valid this cycle
in_ready  output  1  block accepts d this cycle
y0, y1, y2, y3  output  WIDTH  lane holding registers
v  output  4  per-lane valid; bit i qualifies yi
rdy  input  4  per-lane consumer ready; bit i drains lane i
cur_sel  output  2  lane targeted this cycle

Behaviour:
- Reset, asynchronous on reset_n low:
  - y0..y3 = 0, v = 4'b0000, round-robin pointer ptr = 2'b00.
  - in_ready = 1 immediately, because the target lane is empty.
- Lane selection (combinational):
  - cur_sel = auto ? ptr : s.
  - A change of auto or s takes effect in the same cycle.
- Acceptance:
  - in_ready = ~v[cur_sel] | rdy[cur_sel].
  - in_ready never depends on in_valid.
  - A transfer occurs when in_valid & in_ready.
- On a transfer, at the next clk edge: y[cur_sel] <= d and v[cur_sel] <= 1. Latency is 1 cycle, from acceptance to v set.
- Drain: lane i is consumed when v[i] & rdy[i]. At the next edge, v[i] <= 0 unless lane i is written in the same cycle.
- Simultaneous drain and write on the same lane:
  - v stays 1 and y takes the new d.
  - Full throughput of one word per cycle on a continuously ready lane.
- Hold rule: while v[i]=1 and rdy[i]=0, yi stays stable and v[i] stays 1.
- y values when v=0:
  - yi keeps its last value; it is not cleared on drain.
  - The consumer must ignore yi while v[i]=0.
- Round-robin pointer:
  - Increments by 1 on each transfer while auto=1, wrapping 3 -> 0.
  - Does not move on a stall (in_ready=0) or with no in_valid.
  - Does not move while auto=0; it is frozen and resumes from its held value when auto returns to 1.
- Stall on a full lane:
  - If the target lane is full and its rdy=0, in_ready=0, even if other lanes are empty.
  - No bypass to another lane; ordering is strictly by selection.
- Other lanes: lanes that are not selected drain independently in the same cycle as a transfer.
- Reset mid-operation: all pending lane data is discarded (v=0) and ptr returns to 0. The upstream must retry any word that was presented but not accepted.

Optional Feature:
- Macro: DEMUX4_STATS_EN.
- Defined:
  - Adds output port xfer_cnt [15:0], reset to 0.
  - Increments by 1 on every accepted transfer; wraps 16'hFFFF -> 16'h0000.
  - Updated on the same edge as the lane write.
- Not defined: the port and counter are absent. Remaining behaviour is identical.

Test Plan:
- Explicit select: auto=0, rdy=4'b1111, in_valid=1, present d/s pairs 0000/00, 0101/01, 1010/10, 1111/11 on consecutive cycles.
  -> One cycle after each: y0=0000, y1=0101, y2=1010, y3=1111 with the matching v bit set.
  -> in_ready=1 throughout.
- Round-robin wrap: auto=1, rdy=4'b1111, send 5 words 1..5.
  -> cur_sel sequence 0,1,2,3,0.
  -> Final contents y0=5, y1=2, y2=3, y3=4; ptr=1 at the end.
- Backpressure: auto=0, s=10, rdy=0; send 1010, then present 0101.
  -> v[2]=1, in_ready=0, y2 holds 1010.
  -> Raise rdy[2] for one cycle: 0101 is accepted that cycle, v[2] stays 1, y2=0101 next cycle.
- Auto freeze: auto=1, send 2 words (ptr=2); set auto=0, s=00, send 1 word to lane 0; set auto=1, send 1 word.
  -> The last word lands in lane 2 and ptr becomes 3.
- Async reset mid-stream: hold rdy=0 with lanes 0–2 full; pulse reset_n low between edges.
  -> v=0000, y0..y3=0, ptr=0, in_ready=1 immediately, without waiting for a clock edge.
- With DEMUX4_STATS_EN defined: 3 transfers plus 2 stalled cycles -> xfer_cnt=3.
  - Preload by 65535 transfers, then one more -> xfer_cnt=0.

Source files
------------

// File: rtl/demux4_reg_if.sv
// rtl/demux4_reg_if.sv - handshake and lane bundle for the registered 1-to-4 demux (optional DEMUX4_STATS_EN)
interface demux4_reg_if #(
   parameter int WIDTH = 4
);
   // upstream word and lane selection
   logic [WIDTH-1:0] d;
   logic [1:0]       s;
   logic             auto;
   logic             in_valid;
   logic             in_ready;

   // downstream lane holding registers and their handshake
   logic [WIDTH-1:0] y0;
   logic [WIDTH-1:0] y1;
   logic [WIDTH-1:0] y2;
   logic [WIDTH-1:0] y3;
   logic [3:0]       v;
   logic [3:0]       rdy;

   // lane targeted by the current cycle
   logic [1:0]       cur_sel;

`ifdef DEMUX4_STATS_EN
   logic [15:0]      xfer_cnt;
`endif

   // producer/consumer side: drives the word, the selection and the lane ready bits
   modport master (
      output d,
      output s,
      output auto,
      output in_valid,
      output rdy,
      input  in_ready,
      input  y0,
      input  y1,
      input  y2,
      input  y3,
      input  v,
      input  cur_sel
`ifdef DEMUX4_STATS_EN
      ,
      input  xfer_cnt
`endif
   );

   // demux side
   modport slave (
      input  d,
      input  s,
      input  auto,
      input  in_valid,
      input  rdy,
      output in_ready,
      output y0,
      output y1,
      output y2,
      output y3,
      output v,
      output cur_sel
`ifdef DEMUX4_STATS_EN
      ,
      output xfer_cnt
`endif
   );
endinterface

// File: rtl/demux4_reg.sv
// rtl/demux4_reg.sv - registered 1-to-4 demux with per-lane holding registers (optional DEMUX4_STATS_EN)
module demux4_reg #(
   parameter int WIDTH = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   demux4_reg_if.slave  bus
);

   logic [1:0]       ptr;
   logic [1:0]       sel;
   logic             accept_ok;
   logic             xfer;
   logic [3:0]       wr_hit;
   logic [3:0]       drain;
   logic [3:0]       lane_v;
   logic [WIDTH-1:0] lane_y [4];

   // lane choice: round-robin pointer in auto mode, explicit select otherwise
   always_comb begin
      sel = bus.s;
      if (bus.auto) begin
         sel = ptr;
      end
   end

   // a lane can take a word if it is empty or being drained this very cycle;
   // deliberately independent of in_valid so upstream may wait on it
   always_comb begin
      accept_ok = ~lane_v[sel] | bus.rdy[sel];
      xfer      = bus.in_valid & accept_ok;
      wr_hit    = 4'b0000;
      if (xfer) begin
         wr_hit = 4'b0001 << sel;
      end
      drain     = lane_v & bus.rdy;
   end

   // lane holding registers: a write wins over a drain so a continuously
   // ready lane sustains one word per cycle; data is kept after a drain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lane_v <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            lane_y[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (wr_hit[i]) begin
               lane_y[i] <= bus.d;
               lane_v[i] <= 1'b1;
            end else if (drain[i]) begin
               lane_v[i] <= 1'b0;
            end
         end
      end
   end

   // round-robin pointer advances only on accepted words in auto mode,
   // and is frozen while explicit selection is in use
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= 2'b00;
      end else if (xfer && bus.auto) begin
         ptr <= ptr + 2'd1;
      end
   end

`ifdef DEMUX4_STATS_EN
   logic [15:0] cnt;

   // accepted-transfer counter, free-running with natural 16-bit wrap
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= 16'h0000;
      end else if (xfer) begin
         cnt <= cnt + 16'h0001;
      end
   end

   assign bus.xfer_cnt = cnt;
`endif

   assign bus.in_ready = accept_ok;
   assign bus.cur_sel  = sel;
   assign bus.v        = lane_v;
   assign bus.y0       = lane_y[0];
   assign bus.y1       = lane_y[1];
   assign bus.y2       = lane_y[2];
   assign bus.y3       = lane_y[3];

endmodule

// File: tb/tb_demux4_reg.sv
// tb/tb_demux4_reg.sv - scoreboard bench for demux4_reg against a lane-occupancy reference model
module tb_demux4_reg;

   logic clk;
   logic reset_n;

   demux4_reg_if #(.WIDTH(4)) bus ();

   demux4_reg #(.WIDTH(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] lane;
      logic [3:0] data;
   } ent_t;

   int checks = 0;
   int errors = 0;

   // scoreboard: words expected on each lane in order, plus per-cycle control expectations
   ent_t       sb [$];
   logic [6:0] ctl_q [$];

   // reference model state: which lanes hold a word, and the round-robin position
   logic [3:0] m_full;
   int         m_ptr;
   int         n_xfer;
   bit         p_wr;
   int         p_lane;
   logic [3:0] p_rdy;
   bit         p_auto;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int lane_y(input int i);
      case (i)
         0: return int'(bus.y0);
         1: return int'(bus.y1);
         2: return int'(bus.y2);
         default: return int'(bus.y3);
      endcase
   endfunction

   // one stimulus cycle: fold the previous edge into the model, then present new inputs
   task automatic drive(input logic [3:0] dd, input logic [1:0] ss, input bit aa,
                        input bit vv, input logic [3:0] rr);
      int  esel;
      bit  erdy;
      ent_t e;
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
         if (p_wr && p_lane == i) m_full[i] = 1'b1;
         else if (m_full[i] && p_rdy[i]) m_full[i] = 1'b0;
      end
      if (p_wr && p_auto) m_ptr = (m_ptr + 1) % 4;
      bus.d        = dd;
      bus.s        = ss;
      bus.auto     = aa;
      bus.in_valid = vv;
      bus.rdy      = rr;
      esel = aa ? m_ptr : int'(ss);
      erdy = !m_full[esel] || rr[esel];
      ctl_q.push_back({erdy, 2'(esel), m_full});
      p_wr   = vv && erdy;
      p_lane = esel;
      p_rdy  = rr;
      p_auto = aa;
      if (p_wr) begin
         e.lane = 2'(esel);
         e.data = dd;
         sb.push_back(e);
         n_xfer++;
      end
   endtask

   // reset pulse asserted between edges; outputs must clear without a clock
   task automatic do_reset();
      @(posedge clk);
      #2;
      reset_n      = 1'b0;
      bus.in_valid = 1'b0;
      bus.rdy      = 4'b0000;
      bus.auto     = 1'b1;
      bus.s        = 2'b00;
      bus.d        = 4'h0;
      sb.delete();
      ctl_q.delete();
      m_full = 4'b0000;
      m_ptr  = 0;
      n_xfer = 0;
      p_wr   = 0;
      #1;
      chk("rst_v", int'(bus.v), 0);
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_cur_sel", int'(bus.cur_sel), 0);
      chk("rst_y", lane_y(0) + lane_y(1) + lane_y(2) + lane_y(3), 0);
      @(posedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   // monitor: checks control expectations and every word held on a valid lane
   initial begin
      logic [6:0] c;
      int idx;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (ctl_q.size() > 0) begin
               c = ctl_q.pop_front();
               chk("in_ready", int'(bus.in_ready), int'(c[6]));
               chk("cur_sel", int'(bus.cur_sel), int'(c[5:4]));
               chk("v", int'(bus.v), int'(c[3:0]));
            end
            for (int i = 0; i < 4; i++) begin
               if (bus.v[i]) begin
                  idx = -1;
                  for (int k = 0; k < sb.size(); k++) begin
                     if (idx < 0 && int'(sb[k].lane) == i) idx = k;
                  end
                  if (idx < 0) begin
                     checks++;
                     errors++;
                     $display("FAIL lane%0d_unexpected actual=%0d expected=none", i, lane_y(i));
                  end else begin
                     chk($sformatf("lane%0d_data", i), lane_y(i), int'(sb[idx].data));
                     if (bus.rdy[i]) sb.delete(idx);
                  end
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n      = 1'b0;
      bus.d        = 4'h0;
      bus.s        = 2'b00;
      bus.auto     = 1'b1;
      bus.in_valid = 1'b0;
      bus.rdy      = 4'b0000;
      m_full = 4'b0000;
      m_ptr  = 0;
      n_xfer = 0;
      p_wr   = 0;
      p_lane = 0;
      p_rdy  = 4'b0000;
      p_auto = 0;
      do_reset();

      // explicit select into all four lanes
      drive(4'h0, 2'd0, 0, 1, 4'hF);
      drive(4'h5, 2'd1, 0, 1, 4'hF);
      drive(4'hA, 2'd2, 0, 1, 4'hF);
      drive(4'hF, 2'd3, 0, 1, 4'hF);
      drive(4'h0, 2'd0, 0, 0, 4'h0);
      #1;
      chk("sel_y0", lane_y(0), 0);
      chk("sel_y1", lane_y(1), 5);
      chk("sel_y2", lane_y(2), 10);
      chk("sel_y3", lane_y(3), 15);

      // round-robin wrap
      do_reset();
      for (int w = 1; w <= 5; w++) drive(4'(w), 2'd0, 1, 1, 4'hF);
      drive(4'h0, 2'd0, 1, 0, 4'h0);
      #1;
      chk("rr_y0", lane_y(0), 5);
      chk("rr_y1", lane_y(1), 2);
      chk("rr_y2", lane_y(2), 3);
      chk("rr_y3", lane_y(3), 4);
      chk("rr_ptr", int'(bus.cur_sel), 1);

      // backpressure on lane 2, then simultaneous drain and write
      do_reset();
      drive(4'hA, 2'd2, 0, 1, 4'h0);
      drive(4'h5, 2'd2, 0, 1, 4'h0);
      #1;
      chk("bp_stall", int'(bus.in_ready), 0);
      drive(4'h5, 2'd2, 0, 1, 4'h0);
      drive(4'h5, 2'd2, 0, 1, 4'b0100);
      #1;
      chk("bp_accept", int'(bus.in_ready), 1);
      drive(4'h0, 2'd2, 0, 0, 4'h0);
      #1;
      chk("bp_y2", lane_y(2), 5);
      chk("bp_v2", int'(bus.v[2]), 1);

      // pointer frozen while auto is off
      do_reset();
      drive(4'h1, 2'd0, 1, 1, 4'hF);
      drive(4'h2, 2'd0, 1, 1, 4'hF);
      drive(4'h3, 2'd0, 0, 1, 4'hF);
      drive(4'h6, 2'd0, 1, 1, 4'hF);
      drive(4'h0, 2'd0, 1, 0, 4'h0);
      #1;
      chk("frz_y2", lane_y(2), 6);
      chk("frz_ptr", int'(bus.cur_sel), 3);

      // asynchronous reset with lanes 0-2 full
      drive(4'h1, 2'd0, 0, 1, 4'h0);
      drive(4'h2, 2'd1, 0, 1, 4'h0);
      drive(4'h3, 2'd2, 0, 1, 4'h0);
      drive(4'h0, 2'd0, 0, 0, 4'h0);
      do_reset();

      // randomized traffic
      begin
         bit a;
         a = 1;
         for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(7) == 0) a = ~a;
            if ($urandom_range(499) == 0) do_reset();
            drive(4'($urandom), 2'($urandom), a, $urandom_range(9) < 7, 4'($urandom));
         end
      end

      // drain everything and confirm nothing was lost
      drive(4'h0, 2'd0, 0, 0, 4'hF);
      drive(4'h0, 2'd0, 0, 0, 4'hF);
      drive(4'h0, 2'd0, 0, 0, 4'hF);
      #1;
      chk("sb_empty", sb.size(), 0);
`ifdef DEMUX4_STATS_EN
      chk("xfer_cnt", int'(bus.xfer_cnt), n_xfer % 65536);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
